// File: rtl/loopback_miso_arbiter_if.sv
// loopback_miso_arbiter_if: requester byte streams plus the merged MISO AXIS stream
interface loopback_miso_arbiter_if #(parameter int N_REQ = 3);
  logic [8*N_REQ-1:0] req_tdata;
  logic [N_REQ-1:0] req_tvalid;
  logic [N_REQ-1:0] req_tlast;
  logic [N_REQ-1:0] req_tready;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready;
  modport master (
    output req_tdata, req_tvalid, req_tlast, m_axis_tready,
    input  req_tready, m_axis_tdata, m_axis_tvalid
  );
  modport slave (
    input  req_tdata, req_tvalid, req_tlast, m_axis_tready,
    output req_tready, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/loopback_miso_arbiter.sv
// loopback_miso_arbiter: frame-level round-robin arbiter feeding the SPI loopback MISO stream
module loopback_miso_arbiter #(
  parameter int N_REQ = 3,
  parameter int GW = $clog2(N_REQ),
  parameter int HIGH_WATER = 24,
  parameter int MAX_BEATS = 64
) (
  input  logic clk_core,
  input  logic clk_core_resn,
  input  logic enable,
  loopback_miso_arbiter_if.slave bus,
  input  logic [31:0] miso_write_size,
  input  logic err_clear,
  output logic busy,
  output logic [GW-1:0] grant_id,
  output logic [15:0] frame_count,
  output logic err_long_frame
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  logic [GW-1:0] last_grant, win, win_hi, win_lo;
  logic found_hi, beat, start;
  logic [7:0] beat_cnt;
  // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid index.
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    found_hi = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (bus.req_tvalid[i]) begin
        win_lo = GW'(i);
        if (i > int'(last_grant)) begin
          win_hi = GW'(i);
          found_hi = 1'b1;
        end
      end
    win = found_hi ? win_hi : win_lo;
  end
  assign busy = state == XFER;
  assign bus.m_axis_tdata = 8'(bus.req_tdata >> {grant_id, 3'b000});
  assign bus.m_axis_tvalid = busy & bus.req_tvalid[grant_id];
  assign bus.req_tready = busy ? (N_REQ'(bus.m_axis_tready) << grant_id) : '0;
  assign beat = bus.m_axis_tvalid & bus.m_axis_tready;
  assign start = enable && miso_write_size < 32'(HIGH_WATER) && |bus.req_tvalid;
  always_ff @(posedge clk_core or negedge clk_core_resn)
    if (!clk_core_resn) begin
      state <= IDLE;
      grant_id <= '0;
      last_grant <= GW'(N_REQ - 1);
      beat_cnt <= '0;
      frame_count <= '0;
      err_long_frame <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (start) begin
          state <= XFER;
          grant_id <= win;
          last_grant <= win;
          beat_cnt <= '0;
        end
      end else if (beat) begin
        beat_cnt <= beat_cnt + 8'(beat_cnt != 8'hFF);
        if (bus.req_tlast[grant_id]) begin
          frame_count <= frame_count + 16'd1;
          state <= IDLE;
        end
      end
      if (beat && int'(beat_cnt) >= MAX_BEATS) err_long_frame <= 1'b1;
      else if (err_clear) err_long_frame <= 1'b0;
    end
endmodule

// File: doc/loopback_miso_arbiter.md
# loopback_miso_arbiter

Frame-level round-robin arbiter that shares the single MISO byte stream of the SPI loopback interface between N_REQ byte-stream requesters in the clk_core domain. It sits in front of the loopback MISO AXIS slave (miso_s_axis_*) and keeps every frame contiguous: it never interleaves requesters inside a frame. It starts a new frame only while the MISO FIFO fill level is below a high-water mark. It also provides frame accounting and an oversize-frame error flag for register readback.

## Interface
Parameters:
- N_REQ, 3, number of requesters (2..8)
- GW, $clog2(N_REQ), grant index width
- HIGH_WATER, 24, a new frame may start only while miso_write_size < HIGH_WATER
- MAX_BEATS, 64, frame length (beats) above which err_long_frame is set

Ports:
- clk_core  in  1  core clock; only clock, all logic on rising edge
- clk_core_resn  in  1  asynchronous, active-low reset
- enable  in  1  arbitration enable; sampled only in IDLE
- req_tdata  in  8*N_REQ  requester bytes; requester i uses bits [8i+7:8i]
- req_tvalid  in  N_REQ  per-requester valid
- req_tlast  in  N_REQ  per-requester end-of-frame
- req_tready  out  N_REQ  per-requester ready
- m_axis_tdata  out  8  to MISO FIFO slave tdata
- m_axis_tvalid  out  1  to MISO FIFO slave tvalid
- m_axis_tready  in  1  from MISO FIFO slave tready
- miso_write_size  in  32  MISO FIFO write-side data count
- err_clear  in  1  single-cycle clear of err_long_frame
- busy  out  1  high while a frame is granted (XFER)
- grant_id  out  GW  index of the current or last granted requester
- frame_count  out  16  completed frames, wraps 0xFFFF->0
- err_long_frame  out  1  sticky oversize-frame flag

## Operation
- FSM states: IDLE, XFER.
- IDLE → XFER:
  - Condition: enable=1, miso_write_size < HIGH_WATER (unsigned 32-bit compare) and at least one req_tvalid=1.
  - Winner: the first valid requester at or after (last_grant+1) mod N_REQ, scanning upward with wrap.
  - Registered on that edge: grant_id, last_grant and beat_cnt=0.
- XFER datapath, combinational pass-through:
  - m_axis_tdata = req_tdata[grant_id].
  - m_axis_tvalid = req_tvalid[grant_id].
  - req_tready[grant_id] = m_axis_tready.
  - All other req_tready = 0.
- In IDLE: m_axis_tvalid=0 and all req_tready=0.
- Beat: a cycle with m_axis_tvalid & m_axis_tready in XFER.
  - Every beat: beat_cnt increments, 8-bit, saturating at 255.
  - Beat with req_tlast[grant_id]=1: frame_count+1 and FSM → IDLE.
- Oversize frame:
  - Set err_long_frame when a beat is taken while beat_cnt ≥ MAX_BEATS, i.e. the frame exceeds MAX_BEATS beats.
  - The frame still completes normally; the arbiter never truncates it.
  - err_clear clears the flag. If set and clear occur in the same cycle, set wins.
- enable deasserted mid-frame: no effect until the frame ends; afterwards no new grant.
- Watermark rising mid-frame: no effect. The check is made at frame start only, so a frame can overfill only by its own length. Software sizes HIGH_WATER accordingly.
- tlast is meaningful only with tvalid. Requester data is never reordered or dropped.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: grant_id=0, frame_count=0, err_long_frame=0, busy=0, m_axis_tvalid=0, req_tready=0, m_axis_tdata=req_tdata[0].
  - last_grant=N_REQ-1, so requester 0 has first priority.
- Arbitration latency:
  - The first byte can be presented the cycle after the IDLE cycle in which the request is seen: 1 cycle.
- Frame spacing:
  - At least one IDLE cycle between consecutive frames, including frames from the same requester.
  - A one-beat frame occupies 2 cycles minimum.
- busy tracks state: it rises and falls on the same edges as XFER entry and exit.
- Throughput inside a frame: 1 byte/cycle when source and sink are both ready. There are no added bubbles.
- Asynchronous reset mid-frame: all of the above take their reset values immediately, and the partial frame is abandoned.

## Test plan
- Single requester 1: enable=1, write_size=0, 4-byte frame 0xA1..0xA4, sink always ready.
  - grant_id=1.
  - busy high for exactly 4 cycles.
  - Bytes out in order.
  - frame_count=1, err_long_frame=0.
- Round robin: requesters 0, 1 and 2 each hold a continuously valid 2-byte frame, repeated.
  - Grant order 0,1,2,0,1,2.
  - 1 IDLE cycle between frames.
  - frame_count=6 after 6 frames.
- Watermark: write_size=24 with req0 valid.
  - No grant, busy=0, req_tready=0.
  - Drop write_size to 23: grant on the next edge.
  - Raise write_size to 40 mid-frame: the frame still completes.
- Backpressure and disable: 3-byte frame with m_axis_tready toggling 1,0,1,0,1; enable dropped after beat 1.
  - Exactly 3 beats, data intact.
  - No new grant after tlast while enable=0.
- Oversize frame, MAX_BEATS=64: 65-byte frame.
  - err_long_frame rises on beat 65.
  - Frame completes, frame_count+1.
  - err_clear pulse → 0.
  - err_clear during an oversize beat → stays 1.
- Reset mid-frame after 2 of 5 bytes; also frame_count preloaded by 65535 frames, then one more frame.
  - Reset: outputs go to their reset values immediately, and the next grant goes to requester 0.
  - Preloaded counter: frame_count wraps to 0.
